data_memory: RTL and testbench
==============================

Name: data_memory

Overview:
- 32-word × 32-bit data memory for the rv32i datapath.
- Synchronous write on the rising clock edge; combinational (asynchronous) read.
- Sits behind the memory stage. The ALU result's word address drives `addres`; store data drives `wd`; `rd` feeds the load path.
- Synchronous active-high reset clears the array.

Parameters:
- ADDR_W, 5, address width in words.
- DATA_W, 32, word width in bits.
- DEPTH, 1<<ADDR_W (32), number of words. Derived; not to be overridden independently.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- we  input  1  write enable.
- addres  input  ADDR_W  word address for both read and write.
- wd  input  DATA_W  write data.
- rd  output  DATA_W  read data, combinational from `addres`.

Behaviour:
- One clock; reset is synchronous and active-high, sampled only on the rising edge of `clk`.
- Storage is an array `mem[0..DEPTH-1]` of DATA_W-bit registers.
- Read:
  - `rd = mem[addres]`, purely combinational, zero-cycle latency.
  - No read enable.
  - After a write edge, `rd` reflects the new value immediately if `addres` is unchanged.
- Write:
  - At a posedge with `rst=0` and `we=1`: `mem[addres] <= wd`.
  - Only the addressed word changes; all others hold.
  - With `we=0`, the array holds.
- Reset:
  - At a posedge with `rst=1`, every word is set to its reset value: 0, or the preset table with DM_INIT_EN.
  - Reset has priority over a simultaneous write; the write is dropped.
  - Reset asserted mid-sequence takes effect at that edge; earlier writes are lost.
- Reset value of output: `rd` reads 0 (or the preset word) the same cycle after the reset edge.
- Address boundaries:
  - `addres` spans 0..31 fully; no out-of-range case exists.
  - Address 31 is the last word; no wrap logic.
- Address or `wd` changes between edges have no effect on the array; only sampled values at the edge matter.
- X on `we` at an edge is a verification error; no defined behaviour is required.
- No handshake, no stall, no byte enables; full-word access only.

Optional Feature:
- Macro DM_INIT_EN.
- Defined: the reset value of word i is `DM_INIT_TABLE[i]` from the package, a 32-entry constant array, e.g. word i = 32'h0000_0000 + i. This value is also loaded as the power-on initial value.
- Undefined: reset and initial value of every word is 32'h0000_0000.
- Read/write timing is identical in both builds.

Decomposition:
- Package `dm_pkg`:
  - ADDR_W and DATA_W defaults.
  - DEPTH.
  - `dm_word_t` typedef (logic [DATA_W-1:0]).
  - `dm_addr_t` typedef (logic [ADDR_W-1:0]).
  - DM_INIT_TABLE constant (only referenced under DM_INIT_EN).
- No sub-module: the single storage array and read mux are one module.

Test Plan:
- Reset then sweep (rst=1 one edge, we=0, addres 0..31) -> `rd`=0x00000000 every word; with DM_INIT_EN, `rd`=DM_INIT_TABLE[i].
- Write/readback (we=1, addres=10, wd=0x00000019, one edge) -> `rd`=0x00000019 right after the edge. Then addres=15, wd=0x00000021, one edge -> `rd`=0x00000021.
- Hold with we=0 (addres=10, wd=0xDEADBEEF, several edges) -> `rd` stays 0x00000019. Full sweep 0..31 -> only [10]=0x19 and [15]=0x21 differ from reset values.
- Boundary (write 0xFFFFFFFF to addr 31 and 0x12345678 to addr 0) -> both read back exactly; addr 30 and addr 1 are unchanged.
- Reset vs write (rst=1 and we=1, addres=5, wd=0xAAAA5555, same edge) -> [5] holds its reset value; earlier [10]/[15] writes are cleared.
- Combinational read (change `addres` between edges with we=0) -> `rd` follows within the same cycle, with no clock needed.

Source files
------------

// File: rtl/dm_pkg.sv
// Shared constants and types for the rv32i data memory.
// DM_INIT_TABLE holds the preset contents used when the design is built
// with DM_INIT_EN defined; otherwise every word resets to zero.
package dm_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
    // Always derived from ADDR_W so the address space is fully populated.
    localparam int DEPTH  = 1 << ADDR_W;

    typedef logic [DATA_W-1:0] dm_word_t;
    typedef logic [ADDR_W-1:0] dm_addr_t;
    typedef dm_word_t          dm_table_t [DEPTH];

    // Preset contents: word i holds the value i.
    function automatic dm_table_t build_init_table();
        dm_table_t t;
        for (int i = 0; i < DEPTH; i++) begin
            t[i] = DATA_W'(i);
        end
        return t;
    endfunction

    localparam dm_table_t DM_INIT_TABLE = build_init_table();

endpackage

// File: rtl/data_memory_if.sv
// Memory-stage bus into the data memory: word address, write enable,
// store data out and load data back.
// No handshake: a write happens on every rising edge where we=1, and rd
// is a pure combinational function of addres.
interface data_memory_if;
    import dm_pkg::*;

    logic     we;
    dm_addr_t addres;
    dm_word_t wd;
    dm_word_t rd;

    modport master (
        output we,
        output addres,
        output wd,
        input  rd
    );

    modport slave (
        input  we,
        input  addres,
        input  wd,
        output rd
    );
endinterface

// File: rtl/data_memory.sv
// 32 x 32-bit data memory: synchronous write, asynchronous read,
// synchronous active-high reset that clears the whole array.
// Build option: DM_INIT_EN selects dm_pkg::DM_INIT_TABLE as the reset and
// power-on contents instead of all zeros.
module data_memory
    import dm_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    data_memory_if.slave  bus
);

`ifdef DM_INIT_EN
    // Power-on contents match the reset contents.
    dm_word_t mem_q [DEPTH] = DM_INIT_TABLE;
`else
    dm_word_t mem_q [DEPTH];
`endif

    // Reset value of a given word.
    function automatic dm_word_t reset_word(input int idx);
`ifdef DM_INIT_EN
        return DM_INIT_TABLE[idx];
`else
        return '0;
`endif
    endfunction

    // Storage update: reset wins over a same-edge write; otherwise only the
    // addressed word is written when we=1.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= reset_word(i);
            end
        end else if (bus.we) begin
            mem_q[bus.addres] <= bus.wd;
        end
    end

    // Zero-latency read: every address in 0..DEPTH-1 exists, so no range check.
    always_comb begin
        bus.rd = mem_q[bus.addres];
    end

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: directed test-plan cases followed by
// random read/write/reset traffic compared against an array model.
module tb_data_memory;
    import dm_pkg::*;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    logic [31:0] model [32];
    logic [31:0] exp_q [$];

    data_memory_if bus ();

    data_memory dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] reset_val(input int i);
`ifdef DM_INIT_EN
        return DM_INIT_TABLE[i];
`else
        return 32'h0000_0000;
`endif
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
        end
    endtask

    // ---------------- drivers ----------------
    // Drive one edge's worth of inputs mid-cycle, apply the edge, update the
    // model with what the memory should do, then settle past the edge.
    task automatic cycle(input logic r, input logic w, input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        rst        = r;
        bus.we     = w;
        bus.addres = a;
        bus.wd     = d;
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < 32; i++) model[i] = reset_val(i);
        end else if (w) begin
            model[a] = d;
        end
        #1;
        rst    = 1'b0;
        bus.we = 1'b0;
    endtask

    // Combinational read: set the address, wait a delta-safe step, compare.
    task automatic read_check(input string tag, input logic [4:0] a);
        bus.addres = a;
        exp_q.push_back(model[a]);
        #1;
        check(tag, bus.rd, exp_q.pop_front());
    endtask

    task automatic sweep(input string tag);
        for (int i = 0; i < 32; i++) read_check(tag, 5'(i));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_checks   = 0;
        n_errors   = 0;
        rst        = 1'b1;
        bus.we     = 1'b0;
        bus.addres = '0;
        bus.wd     = '0;
        for (int i = 0; i < 32; i++) model[i] = 32'hxxxx_xxxx;

        // Reset then sweep.
        cycle(1'b1, 1'b0, 5'd0, 32'h0);
        sweep("reset_sweep");

        // Write / immediate readback with address unchanged.
        cycle(1'b0, 1'b1, 5'd10, 32'h0000_0019);
        check("wr10_readback", bus.rd, 32'h0000_0019);
        cycle(1'b0, 1'b1, 5'd15, 32'h0000_0021);
        check("wr15_readback", bus.rd, 32'h0000_0021);

        // Hold with we=0 and junk on wd.
        for (int k = 0; k < 4; k++) begin
            cycle(1'b0, 1'b0, 5'd10, 32'hDEAD_BEEF);
            check("hold_we0", bus.rd, 32'h0000_0019);
        end
        sweep("after_writes_sweep");

        // Address boundaries.
        cycle(1'b0, 1'b1, 5'd31, 32'hFFFF_FFFF);
        cycle(1'b0, 1'b1, 5'd0,  32'h1234_5678);
        read_check("bound_addr31", 5'd31);
        check("bound_addr31_val", bus.rd, 32'hFFFF_FFFF);
        read_check("bound_addr0", 5'd0);
        check("bound_addr0_val", bus.rd, 32'h1234_5678);
        read_check("bound_addr30", 5'd30);
        check("bound_addr30_val", bus.rd, reset_val(30));
        read_check("bound_addr1", 5'd1);
        check("bound_addr1_val", bus.rd, reset_val(1));

        // Reset and write on the same edge: reset wins, earlier writes lost.
        cycle(1'b1, 1'b1, 5'd5, 32'hAAAA_5555);
        check("rst_vs_wr_addr5", bus.rd, reset_val(5));
        read_check("rst_clears10", 5'd10);
        check("rst_clears10_val", bus.rd, reset_val(10));
        read_check("rst_clears15", 5'd15);
        check("rst_clears15_val", bus.rd, reset_val(15));

        // Combinational read between edges, no clock edge needed.
        cycle(1'b0, 1'b1, 5'd7, 32'hCAFE_0007);
        cycle(1'b0, 1'b1, 5'd8, 32'hCAFE_0008);
        @(posedge clk);
        #2;
        bus.addres = 5'd7;
        #1;
        check("comb_rd_7", bus.rd, 32'hCAFE_0007);
        bus.addres = 5'd8;
        #1;
        check("comb_rd_8", bus.rd, 32'hCAFE_0008);
        bus.addres = 5'd9;
        #1;
        check("comb_rd_9", bus.rd, reset_val(9));

        // Random traffic: writes, idles and occasional resets; each edge is
        // followed by a readback of a random address.
        for (int n = 0; n < 400; n++) begin
            logic       r;
            logic       w;
            logic [4:0] a;
            logic [31:0] d;
            r = ($urandom_range(0, 49) == 0);
            w = ($urandom_range(0, 2) != 0);
            a = 5'($urandom_range(0, 31));
            d = $urandom;
            cycle(r, w, a, d);
            check("rand_same_addr", bus.rd, model[a]);
            read_check("rand_other_addr", 5'($urandom_range(0, 31)));
        end
        sweep("final_sweep");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Absolute run-time bound.
    initial begin
        #200000;
        n_errors++;
        $display("FAIL timeout: got=running expected=finished");
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
